byte_serializer: RTL and testbench
==================================

# byte_serializer

Parallel-to-serial front end for the sequence-detection path. It accepts bytes over a valid/ready handshake into a 2-entry buffer and shifts them out one bit at a time on a registered serial line `w_out`, which drives the `w` input of the downstream four-in-a-row sequence detector. Consecutive bytes are emitted with no gap, so runs of identical bits can span byte boundaries. When no data is pending, the line holds a fixed idle level.

## Interface
- `DATA_W`, default 8: byte width; supported range 2..16.
- `CLK_DIV`, default 1: clock cycles each bit is held on `w_out`; must be ≥1.
- `LSB_FIRST`, default 0: 0 sends the MSB first, 1 sends the LSB first.
- `IDLE_BIT`, default 0: level driven on `w_out` when no byte is being shifted.

Ports:
- `Clk`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state.
- `data_in`  in  DATA_W  byte to be sent.
- `data_valid`  in  1  `data_in` is valid this cycle.
- `data_ready`  out  1  buffer can accept a byte; high when buffer count < 2.
- `w_out`  out  1  registered serial bit; goes to the detector `w` input.
- `bit_valid`  out  1  high in the first cycle of every bit period.
- `busy`  out  1  high while in the SHIFT state.
- `frame_done`  out  1  one-cycle pulse in the last cycle of each byte's last bit period.

## Operation
- Buffer: 2-entry FIFO with a count of 0..2.
  - Push on a rising edge when `data_valid & data_ready`.
  - `data_ready` is a function of count only. It is low at count==2 even if a pop occurs in the same cycle.
  - A push while full is ignored.
- Shift FSM has two states, IDLE and SHIFT.
  - IDLE: if count>0 at an edge, pop the head into the shift register, set bit index = 0 and divider = 0, and go to SHIFT.
  - SHIFT: `w_out` = current bit, with order set by `LSB_FIRST`. The divider counts 0..CLK_DIV-1.
  - When the divider wraps, the bit index increments.
  - When the divider wraps at bit index DATA_W-1, the byte is finished:
    - if count>0, pop the next byte at the same edge and stay in SHIFT (no idle cycle);
    - otherwise go to IDLE.
- A push and a pop on the same edge are both legal; count is unchanged.
- `frame_done` is high in the cycle where bit index == DATA_W-1 and divider == CLK_DIV-1.
- Reset, including mid-byte:
  - State goes to IDLE, count=0, and buffer contents are discarded.
  - `w_out`=IDLE_BIT, `bit_valid`=0, `busy`=0, `frame_done`=0.
  - `data_ready` is 1 while Reset is high, but pushes are ignored during reset.
  - A partial byte is lost and not resumed.

## Timing
- Reset values: `w_out`=IDLE_BIT, `bit_valid`=0, `busy`=0, `frame_done`=0, `data_ready`=1.
- Latency: a byte accepted at edge k into an empty FIFO while IDLE has its first bit on `w_out` after edge k+1, with `bit_valid`=1 and `busy`=1.
- Each byte occupies exactly DATA_W×CLK_DIV cycles.
- Back-to-back bytes: the first bit of the next byte appears at the edge immediately after the `frame_done` cycle.
- `w_out`, `bit_valid`, `busy` and `frame_done` are all registered. There is no combinational path from `data_valid` to any output except `data_ready`, which has none.
- Idle return: `w_out`=IDLE_BIT at the edge after the final `frame_done` when the FIFO is empty.

## Test plan
1. **Single byte.** Defaults, push 0x6D at edge 1.
   - `w_out` = 0,1,1,0,1,1,0,1 after edges 2..9, with `bit_valid` high on each.
   - `frame_done` is high in the cycle after edge 9 only.
   - After edge 10: `busy`=0 and `w_out`=0.
2. **Back-to-back, detector stream.** Push 0x6F then 0xF0 on consecutive edges.
   - 16 contiguous bits: 0110 1111 1111 0000, with no gap.
   - `frame_done` pulses exactly twice, 8 cycles apart.
3. **Full/backpressure.** Push A, B, C on edges 1, 2, 3, then hold D valid.
   - `data_ready` is 0 after edge 3.
   - B is popped at edge 10 and `data_ready` returns to 1 after edge 10.
   - D is accepted at edge 11, not at edge 10.
4. **Divider and LSB order.** CLK_DIV=3, LSB_FIRST=1, push 0x01.
   - `w_out`=1 for 3 cycles, then 0 for 21 cycles.
   - `bit_valid` is high every third cycle (8 pulses).
   - `frame_done` is high in cycle 24 only.
5. **Reset mid-byte.** Assert Reset asynchronously between edges during bit 3, with one byte still buffered.
   - Immediately: `w_out`=IDLE_BIT, `busy`=0, `bit_valid`=0, `frame_done`=0.
   - After release: nothing is emitted until a new push, and the first bit appears one edge after the accept.
6. **Idle level and ignored push.** IDLE_BIT=1 with no pushes.
   - `w_out` stays 1 indefinitely.
   - Pulsing `data_valid` while Reset=1 has no effect: count stays 0.

Source files
------------

// File: rtl/byte_serializer.sv
// -----------------------------------------------------------------------------
// byte_serializer
//
// Parallel-to-serial front end for the sequence-detection path. Bytes arrive
// over a valid/ready handshake into a 2-entry FIFO and are shifted out one bit
// at a time on a registered serial line that feeds the detector's `w` input.
// Consecutive bytes are emitted back-to-back with no gap, so runs of equal bits
// may straddle byte boundaries. With nothing pending the line rests at IDLE_BIT.
//
// Parameters
//   DATA_W     byte width (2..16)
//   CLK_DIV    clock cycles each bit is held on w_out (>= 1)
//   LSB_FIRST  0: MSB first, 1: LSB first
//   IDLE_BIT   level on w_out while no byte is being shifted
//
// Ports
//   Clk         in   single clock, rising-edge active
//   Reset       in   asynchronous active-high reset, clears all control state
//   data_in     in   byte to be sent
//   data_valid  in   data_in valid this cycle
//   data_ready  out  FIFO can accept a byte (count < 2); depends on count only
//   w_out       out  registered serial bit
//   bit_valid   out  registered, high in the first cycle of each bit period
//   busy        out  registered, high while in SHIFT
//   frame_done  out  registered, high in the last cycle of a byte's last bit
// -----------------------------------------------------------------------------
module byte_serializer #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 1,
    parameter int LSB_FIRST = 0,
    parameter int IDLE_BIT  = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              w_out,
    output logic              bit_valid,
    output logic              busy,
    output logic              frame_done
);

    // Counter widths are clamped to at least one bit so CLK_DIV=1 still
    // yields a legal (constant-zero) divider register.
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic             IDLE_LVL = (IDLE_BIT != 0);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Bit-order helpers: the shift register always presents the outgoing bit
    // at one end and shifts toward it, so the order is fixed at load time.
    // -------------------------------------------------------------------------
    function automatic logic front_bit(input logic [DATA_W-1:0] s);
        if (LSB_FIRST != 0) begin
            return s[0];
        end
        return s[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] s);
        if (LSB_FIRST != 0) begin
            return s >> 1;
        end
        return s << 1;
    endfunction

    // -------------------------------------------------------------------------
    // FIFO state
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;

    // -------------------------------------------------------------------------
    // Shifter state
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DIV_W-1:0]  div_q, div_d;

    // Registered outputs
    logic              w_out_q, w_out_d;
    logic              bit_valid_q, bit_valid_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic              div_wrap;
    logic              last_bit;

    // Ready is derived from the registered count alone: a full FIFO refuses a
    // byte even in a cycle where the shifter is about to pop, which keeps
    // data_valid out of every output path.
    assign data_ready = (count_q != 2'd2);
    assign push       = data_valid & data_ready;
    assign head       = mem_q[rd_ptr_q];

    assign div_wrap   = (div_q == DIV_LAST);
    assign last_bit   = (bit_idx_q == IDX_LAST);

    // -------------------------------------------------------------------------
    // Shift FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        div_d     = div_q;
        pop       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (count_q != 2'd0) begin
                    pop       = 1'b1;
                    shreg_d   = head;
                    bit_idx_d = '0;
                    div_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (div_wrap) begin
                    div_d = '0;
                    if (last_bit) begin
                        // Chain straight into the next byte when one is
                        // waiting, so the serial stream has no idle gap.
                        if (count_q != 2'd0) begin
                            pop       = 1'b1;
                            shreg_d   = head;
                            bit_idx_d = '0;
                        end else begin
                            state_d   = ST_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shreg_d   = advance(shreg_q);
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        // Push and pop together leave the count unchanged.
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output next-state logic: outputs are registered, so they are computed
    // from the state the shifter will hold after this edge.
    // -------------------------------------------------------------------------
    always_comb begin
        w_out_d      = IDLE_LVL;
        bit_valid_d  = 1'b0;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;

        if (state_d == ST_SHIFT) begin
            w_out_d      = front_bit(shreg_d);
            bit_valid_d  = (div_d == '0);
            busy_d       = 1'b1;
            frame_done_d = (bit_idx_d == IDX_LAST) && (div_d == DIV_LAST);
        end
    end

    // -------------------------------------------------------------------------
    // Control registers (asynchronously reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            bit_idx_q    <= '0;
            div_q        <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            w_out_q      <= IDLE_LVL;
            bit_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            div_q        <= div_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            w_out_q      <= w_out_d;
            bit_valid_q  <= bit_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Data registers: never reset. Their contents only matter once the count
    // or the FSM marks them live, and reset clears those.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
        shreg_q <= shreg_d;
    end

    assign w_out      = w_out_q;
    assign bit_valid  = bit_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_byte_serializer.sv
module tb_byte_serializer;

    logic       Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instance A: defaults (DATA_W=8, CLK_DIV=1, MSB first, idle 0)
    logic       rst_a;
    logic [7:0] din_a;
    logic       dv_a, rdy_a, w_a, bv_a, busy_a, fd_a;

    // Instance B: CLK_DIV=3, LSB first
    logic       rst_b;
    logic [7:0] din_b;
    logic       dv_b, rdy_b, w_b, bv_b, busy_b, fd_b;

    // Instance C: idle level 1
    logic       rst_c;
    logic [7:0] din_c;
    logic       dv_c, rdy_c, w_c, bv_c, busy_c, fd_c;

    byte_serializer u_dut_a (
        .Clk(Clk), .Reset(rst_a), .data_in(din_a), .data_valid(dv_a),
        .data_ready(rdy_a), .w_out(w_a), .bit_valid(bv_a), .busy(busy_a),
        .frame_done(fd_a)
    );

    byte_serializer #(.CLK_DIV(3), .LSB_FIRST(1)) u_dut_b (
        .Clk(Clk), .Reset(rst_b), .data_in(din_b), .data_valid(dv_b),
        .data_ready(rdy_b), .w_out(w_b), .bit_valid(bv_b), .busy(busy_b),
        .frame_done(fd_b)
    );

    byte_serializer #(.IDLE_BIT(1)) u_dut_c (
        .Clk(Clk), .Reset(rst_c), .data_in(din_c), .data_valid(dv_c),
        .data_ready(rdy_c), .w_out(w_c), .bit_valid(bv_c), .busy(busy_c),
        .frame_done(fd_c)
    );

    int errs   = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  t1;
        logic [15:0] t2;
        logic [23:0] stream3;
        int          fd_cnt, fd_first, fd_second, bv_cnt;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        din_a = '0;   din_b = '0;   din_c = '0;
        dv_a  = 1'b0; dv_b  = 1'b0; dv_c  = 1'b0;
        tick();
        tick();

        // ---------------- Reset values ----------------
        check("rst_a_w",     w_a,    0);
        check("rst_a_bv",    bv_a,   0);
        check("rst_a_busy",  busy_a, 0);
        check("rst_a_fd",    fd_a,   0);
        check("rst_a_ready", rdy_a,  1);
        check("rst_b_w",     w_b,    0);
        check("rst_c_w",     w_c,    1);
        check("rst_c_ready", rdy_c,  1);

        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // ---------------- Test 6: pushes during reset are ignored ----------------
        din_c = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            dv_c = 1'b1;
            tick();
            check("t6_rst_ready", rdy_c,  1);
            check("t6_rst_w",     w_c,    1);
            check("t6_rst_busy",  busy_c, 0);
            dv_c = 1'b0;
            tick();
        end
        #2;
        rst_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t6_idle_w",    w_c,    1);
            check("t6_idle_busy", busy_c, 0);
        end

        // ---------------- Test 1: single byte 0x6D ----------------
        t1 = 8'b0110_1101;
        dv_a = 1'b1; din_a = 8'h6D;
        tick();                                   // edge 1: accepted
        dv_a = 1'b0;
        check("t1_latency_busy", busy_a, 0);
        for (int i = 0; i < 8; i++) begin
            tick();                               // edges 2..9
            check("t1_w",    w_a,    t1[7-i]);
            check("t1_bv",   bv_a,   1);
            check("t1_busy", busy_a, 1);
            check("t1_fd",   fd_a,   (i == 7) ? 1 : 0);
        end
        tick();                                   // edge 10
        check("t1_end_busy", busy_a, 0);
        check("t1_end_w",    w_a,    0);
        check("t1_end_fd",   fd_a,   0);
        check("t1_end_bv",   bv_a,   0);

        // ---------------- Test 2: back-to-back 0x6F, 0xF0 ----------------
        t2 = 16'b0110_1111_1111_0000;
        dv_a = 1'b1; din_a = 8'h6F;
        tick();                                   // edge 1
        din_a = 8'hF0;
        tick();                                   // edge 2: first bit out
        dv_a = 1'b0;
        fd_cnt = 0; fd_first = -1; fd_second = -1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick();
            if (i < 16) begin
                check("t2_w",  w_a,  t2[15-i]);
                check("t2_bv", bv_a, 1);
            end
            if (i == 16) begin
                check("t2_idle_busy", busy_a, 0);
                check("t2_idle_w",    w_a,    0);
            end
            if (fd_a) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = i;
                else fd_second = i;
            end
        end
        check("t2_fd_count", fd_cnt, 2);
        check("t2_fd_gap",   fd_second - fd_first, 8);

        // ---------------- Test 3: full / backpressure ----------------
        dv_a = 1'b1; din_a = 8'hA5;
        tick();                                   // edge 1: A
        din_a = 8'h3C;
        tick();                                   // edge 2: B (A popped)
        din_a = 8'h81;
        tick();                                   // edge 3: C
        check("t3_full_ready", rdy_a, 0);
        din_a = 8'h42;                            // D held valid
        for (int i = 4; i <= 9; i++) tick();
        check("t3_full_ready_e9", rdy_a, 0);
        stream3 = '0;
        for (int i = 0; i < 24; i++) begin
            tick();                               // edges 10..33
            stream3[23-i] = w_a;
            if (i == 0) check("t3_ready_e10", rdy_a, 1);
            if (i == 1) begin
                check("t3_ready_e11", rdy_a, 0); // D took the freed slot at edge 11
                dv_a = 1'b0;
            end
            if (i == 8) check("t3_ready_e18", rdy_a, 1);
        end
        check("t3_stream", stream3, 24'h3C8142);
        tick();                                   // edge 34
        check("t3_end_busy", busy_a, 0);

        // ---------------- Test 4: CLK_DIV=3, LSB first, 0x01 ----------------
        dv_b = 1'b1; din_b = 8'h01;
        tick();
        dv_b = 1'b0;
        bv_cnt = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            check("t4_w",  w_b,  (c <= 3) ? 1 : 0);
            check("t4_bv", bv_b, ((c - 1) % 3 == 0) ? 1 : 0);
            check("t4_fd", fd_b, (c == 24) ? 1 : 0);
            if (bv_b) bv_cnt++;
        end
        check("t4_bv_count", bv_cnt, 8);
        tick();
        check("t4_end_busy", busy_b, 0);
        check("t4_end_w",    w_b,    0);

        // ---------------- Test 5: reset mid-byte ----------------
        dv_a = 1'b1; din_a = 8'hF0;
        tick();                                   // edge 1
        din_a = 8'h5A;
        tick();                                   // edge 2: bit 0, 0x5A buffered
        dv_a = 1'b0;
        tick();
        tick();
        tick();                                   // edge 5: bit 3
        check("t5_pre_w",    w_a,    1);
        check("t5_pre_busy", busy_a, 1);
        #2;
        rst_a = 1'b1;
        #1;
        check("t5_rst_w",     w_a,    0);
        check("t5_rst_busy",  busy_a, 0);
        check("t5_rst_bv",    bv_a,   0);
        check("t5_rst_fd",    fd_a,   0);
        check("t5_rst_ready", rdy_a,  1);
        #2;
        rst_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_quiet_busy", busy_a, 0);
            check("t5_quiet_w",    w_a,    0);
        end
        dv_a = 1'b1; din_a = 8'h80;
        tick();                                   // accept edge
        dv_a = 1'b0;
        check("t5_acc_busy", busy_a, 0);
        check("t5_acc_w",    w_a,    0);
        tick();                                   // first bit
        check("t5_first_w",    w_a,    1);
        check("t5_first_busy", busy_a, 1);
        check("t5_first_bv",   bv_a,   1);
        for (int i = 0; i < 8; i++) tick();
        check("t5_end_busy", busy_a, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
